mem_stage: RTL and testbench

Memory-access pipeline stage with its MEM/WB pipeline register, sitting between the EX/MEM register and the write-back stage. It routes each load or store either to the internal data memory or to the peripheral bridge, and generates byte enables and aligned store data. It runs a small handshake FSM that stalls the pipeline for multi-cycle bridge accesses, and registers everything write-back needs: control, ALU result, destination register, DM/bridge select and captured bridge read data.

---
 rtl/mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage plus MEM/WB register: routes loads/stores to data memory
// or the peripheral bridge, and stalls the pipeline while a bridge access is pending.
module mem_stage #(
  parameter logic [31:0] DM_BASE        = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE        = 32'h0000_3000,
  parameter int          BRIDGE_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_exout,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rw,
  input  logic [4:0]  ex_wb_ctrl,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic        dm_we,
  output logic        pr_req,
  output logic        pr_we,
  output logic [31:0] pr_addr,
  output logic [31:0] pr_wdata,
  output logic [3:0]  pr_be,
  input  logic        pr_ready,
  input  logic [31:0] pr_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_ctrl,
  output logic [31:0] wb_exout,
  output logic [4:0]  wb_rw,
  output logic        wb_addr_in_dm,
  output logic [31:0] wb_prrd,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(BRIDGE_TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_ctrl_q, wb_ctrl_d;
  logic [31:0] wb_exout_q, wb_exout_d;
  logic [4:0]  wb_rw_q, wb_rw_d;
  logic        wb_addr_in_dm_q, wb_addr_in_dm_d;
  logic [31:0] wb_prrd_q, wb_prrd_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] dm_off;
  logic        in_dm, is_byte, is_half, aligned;
  logic        mem_op, addr_fault, bridge_go;
  logic        complete, timeout;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Offset compare keeps the window check free of a constant lower bound.
  assign dm_off     = ex_exout - DM_BASE;
  assign in_dm      = dm_off < DM_SIZE;
  assign is_byte    = ex_wb_ctrl[2];
  assign is_half    = ex_wb_ctrl[1] & ~ex_wb_ctrl[2];
  assign aligned    = is_byte | (is_half ? ~ex_exout[0] : (ex_exout[1:0] == 2'b00));
  assign mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
  assign addr_fault = mem_op & ~aligned;
  assign bridge_go  = mem_op & ~in_dm & aligned;

  always_comb begin
    be    = 4'b1111;
    wdata = ex_store_data;
    if (is_byte) begin
      be    = 4'b0001 << ex_exout[1:0];
      wdata = {4{ex_store_data[7:0]}};
    end else if (is_half) begin
      be    = ex_exout[1] ? 4'b1100 : 4'b0011;
      wdata = {2{ex_store_data[15:0]}};
    end
  end

  assign dm_addr  = {ex_exout[31:2], 2'b00};
  assign dm_wdata = wdata;
  assign dm_be    = be;
  assign dm_we    = ex_valid & ex_mem_write & in_dm & aligned;

  assign pr_req   = bridge_go;
  assign pr_we    = bridge_go & ex_mem_write;
  assign pr_addr  = ex_exout;
  assign pr_wdata = wdata;
  assign pr_be    = be;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bridge_go) begin
          if (pr_ready) begin
            complete = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (pr_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
        end else if (cnt_q == TIMEOUT_C) begin
          complete = 1'b1;
          timeout  = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign mem_stall = bridge_go & ~complete;

  // Stalls and empty slots both enter MEM/WB as bubbles; payload fields hold.
  always_comb begin
    wb_valid_d      = 1'b0;
    wb_ctrl_d       = 5'd0;
    wb_exout_d      = wb_exout_q;
    wb_rw_d         = wb_rw_q;
    wb_addr_in_dm_d = wb_addr_in_dm_q;
    wb_prrd_d       = wb_prrd_q;
    addr_err_d      = 1'b0;
    bus_err_d       = 1'b0;
    if (ex_valid && !mem_stall) begin
      wb_valid_d      = 1'b1;
      wb_ctrl_d       = {ex_wb_ctrl[4] & ~addr_fault & ~timeout, ex_wb_ctrl[3:0]};
      wb_exout_d      = ex_exout;
      wb_rw_d         = ex_rw;
      wb_addr_in_dm_d = in_dm;
      if (complete) begin
        wb_prrd_d = timeout ? 32'd0 : pr_rdata;
      end
      addr_err_d      = addr_fault;
      bus_err_d       = timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      wb_valid_q      <= 1'b0;
      wb_ctrl_q       <= 5'd0;
      wb_exout_q      <= 32'd0;
      wb_rw_q         <= 5'd0;
      wb_addr_in_dm_q <= 1'b0;
      wb_prrd_q       <= 32'd0;
      addr_err_q      <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wb_valid_q      <= wb_valid_d;
      wb_ctrl_q       <= wb_ctrl_d;
      wb_exout_q      <= wb_exout_d;
      wb_rw_q         <= wb_rw_d;
      wb_addr_in_dm_q <= wb_addr_in_dm_d;
      wb_prrd_q       <= wb_prrd_d;
      addr_err_q      <= addr_err_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_ctrl       = wb_ctrl_q;
  assign wb_exout      = wb_exout_q;
  assign wb_rw         = wb_rw_q;
  assign wb_addr_in_dm = wb_addr_in_dm_q;
  assign wb_prrd       = wb_prrd_q;
  assign addr_err      = addr_err_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for DM/alignment cases, hand-written bridge
// sequences, and randomized instructions checked against an arithmetic reference.
module tb_mem_stage;

  localparam int          TO      = 15;
  localparam logic [31:0] DM_END  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_exout, ex_store_data;
  logic [4:0]  ex_rw, ex_wb_ctrl;
  logic        ex_mem_read, ex_mem_write;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_we, pr_req, pr_we;
  logic [31:0] pr_addr, pr_wdata;
  logic [3:0]  pr_be;
  logic        pr_ready;
  logic [31:0] pr_rdata;
  logic        mem_stall, wb_valid;
  logic [4:0]  wb_ctrl, wb_rw;
  logic [31:0] wb_exout, wb_prrd;
  logic        wb_addr_in_dm, addr_err, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.DM_BASE(32'h0), .DM_SIZE(DM_END), .BRIDGE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_exout(ex_exout),
    .ex_store_data(ex_store_data), .ex_rw(ex_rw), .ex_wb_ctrl(ex_wb_ctrl),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_we(dm_we),
    .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr), .pr_wdata(pr_wdata),
    .pr_be(pr_be), .pr_ready(pr_ready), .pr_rdata(pr_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_ctrl(wb_ctrl),
    .wb_exout(wb_exout), .wb_rw(wb_rw), .wb_addr_in_dm(wb_addr_in_dm),
    .wb_prrd(wb_prrd), .addr_err(addr_err), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic [4:0] c, input logic rd, input logic wr);
    ex_valid      = v;
    ex_exout      = a;
    ex_store_data = d;
    ex_rw         = r;
    ex_wb_ctrl    = c;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    pr_ready = 1'b0;
    pr_rdata = 32'h0;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  // Reference: access size in bytes, alignment, enables and lane data from plain arithmetic.
  function automatic int size_of(input logic [4:0] c);
    return c[2] ? 1 : (c[1] ? 2 : 4);
  endfunction

  function automatic logic ref_aligned(input logic [31:0] a, input logic [4:0] c);
    return (a % size_of(c)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [4:0] c);
    int s;
    int lane;
    s = size_of(c);
    lane = int'(a % 4) / s * s;
    return 4'(((1 << s) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [4:0] c);
    int s;
    s = size_of(c);
    if (s == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  ctrl;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        aerr;
    logic        in_dm;
    logic [4:0]  wbc;
  } vec_t;

  vec_t tbl[9];

  // Model of MEM/WB contents for the randomized phase.
  logic        m_valid, m_dm, m_aerr, m_berr;
  logic [4:0]  m_ctrl, m_rw;
  logic [31:0] m_exout, m_prrd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h0000_0010, 32'h1234_5678, 5'b00000, 1'b0, 1'b1, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[1] = '{32'h0000_0013, 32'h0000_00AB, 5'b00100, 1'b0, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b1, 1'b0, 1'b1, 5'b00100};
    tbl[2] = '{32'h0000_0012, 32'h0000_1234, 5'b00010, 1'b0, 1'b1, 4'b1100, 32'h1234_1234, 1'b1, 1'b0, 1'b1, 5'b00010};
    tbl[3] = '{32'h0000_0002, 32'h0000_0000, 5'b11000, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'b01000};
    tbl[4] = '{32'h0000_0011, 32'h0000_5555, 5'b00010, 1'b0, 1'b1, 4'b0011, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 5'b00010};
    tbl[5] = '{32'h0000_0001, 32'h0000_0000, 5'b11101, 1'b1, 1'b0, 4'b0010, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'b11101};
    tbl[6] = '{32'h0000_2FFC, 32'hCAFE_F00D, 5'b00000, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[7] = '{32'h0000_3002, 32'h0000_0000, 5'b11000, 1'b1, 1'b0, 4'b1111, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'b01000};
    tbl[8] = '{32'h0000_2FFE, 32'h0000_0000, 5'b11011, 1'b1, 1'b0, 4'b1100, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'b11011};

    // Reset state
    do_reset();
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_ctrl", wb_ctrl, 0);
    chk("rst wb_exout", wb_exout, 0);
    chk("rst wb_rw", wb_rw, 0);
    chk("rst wb_addr_in_dm", wb_addr_in_dm, 0);
    chk("rst wb_prrd", wb_prrd, 0);
    chk("rst addr_err", addr_err, 0);
    chk("rst bus_err", bus_err, 0);
    @(negedge clk);
    chk("rst mem_stall", mem_stall, 0);
    chk("rst pr_req", pr_req, 0);
    chk("rst dm_we", dm_we, 0);
    next_cycle();

    // Single-cycle DM and misaligned accesses
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].addr, tbl[i].data, 5'(i + 1), tbl[i].ctrl, tbl[i].rd, tbl[i].wr);
      pr_ready = 1'b1;
      @(negedge clk);
      chk("vec dm_we", dm_we, tbl[i].we);
      chk("vec dm_addr", dm_addr, tbl[i].addr & ~32'h3);
      chk("vec pr_req", pr_req, 0);
      chk("vec mem_stall", mem_stall, 0);
      if (!tbl[i].aerr) chk("vec dm_be", dm_be, tbl[i].be);
      if (tbl[i].we) chk("vec dm_wdata", dm_wdata, tbl[i].wdata);
      next_cycle();
      chk("vec wb_valid", wb_valid, 1);
      chk("vec wb_ctrl", wb_ctrl, tbl[i].wbc);
      chk("vec wb_exout", wb_exout, tbl[i].addr);
      chk("vec wb_rw", wb_rw, i + 1);
      chk("vec wb_addr_in_dm", wb_addr_in_dm, tbl[i].in_dm);
      chk("vec addr_err", addr_err, tbl[i].aerr);
      $display("vector %0d addr=%08h ctrl=%05b rd=%0d wr=%0d", i, tbl[i].addr, tbl[i].ctrl, tbl[i].rd, tbl[i].wr);
    end
    pr_ready = 1'b0;

    // Bridge lw with pr_ready on the 4th cycle
    drive(1'b1, 32'h0000_7F00, 32'h0, 5'd7, 5'b11000, 1'b1, 1'b0);
    for (int j = 0; j <= 3; j++) begin
      pr_ready = (j == 3);
      pr_rdata = (j == 3) ? 32'hDEAD_BEEF : 32'h1111_1111 * j;
      @(negedge clk);
      chk("br3 mem_stall", mem_stall, j < 3);
      chk("br3 pr_req", pr_req, 1);
      chk("br3 pr_we", pr_we, 0);
      chk("br3 pr_addr", pr_addr, 32'h0000_7F00);
      chk("br3 pr_be", pr_be, 4'b1111);
      next_cycle();
      if (j < 3) chk("br3 bubble", wb_valid, 0);
    end
    chk("br3 wb_valid", wb_valid, 1);
    chk("br3 wb_prrd", wb_prrd, 32'hDEAD_BEEF);
    chk("br3 regWrite", wb_ctrl[4], 1);
    chk("br3 wb_addr_in_dm", wb_addr_in_dm, 0);
    chk("br3 bus_err", bus_err, 0);
    $display("bridge lw 0x7F00 ready after 3 cycles");

    // Bridge lw that never gets pr_ready
    drive(1'b1, 32'h0000_8000, 32'h0, 5'd9, 5'b11000, 1'b1, 1'b0);
    pr_ready = 1'b0;
    for (int j = 0; j <= TO; j++) begin
      pr_rdata = $urandom;
      @(negedge clk);
      chk("tmo mem_stall", mem_stall, j < TO);
      chk("tmo pr_req", pr_req, 1);
      next_cycle();
      if (j < TO) chk("tmo early bus_err", bus_err, 0);
    end
    chk("tmo bus_err", bus_err, 1);
    chk("tmo wb_valid", wb_valid, 1);
    chk("tmo wb_prrd", wb_prrd, 0);
    chk("tmo regWrite", wb_ctrl[4], 0);
    // Back in IDLE: a zero-wait bridge store must not stall
    drive(1'b1, 32'h0000_9004, 32'h0000_00AA, 5'd0, 5'b00100, 1'b0, 1'b1);
    pr_ready = 1'b1;
    @(negedge clk);
    chk("tmo idle stall", mem_stall, 0);
    chk("tmo idle pr_we", pr_we, 1);
    chk("tmo idle pr_be", pr_be, 4'b0001);
    chk("tmo idle pr_wdata", pr_wdata, 32'hAAAA_AAAA);
    next_cycle();
    chk("tmo bus_err pulse", bus_err, 0);
    chk("tmo idle wb_valid", wb_valid, 1);
    $display("bridge lw 0x8000 timeout then zero-wait sb 0x9004");

    // Reset during the second WAIT cycle
    drive(1'b1, 32'h0000_4000, 32'h0, 5'd3, 5'b11000, 1'b1, 1'b0);
    pr_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("rstw stall", mem_stall, 1);
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("rstw wb_valid", wb_valid, 0);
    chk("rstw wb_ctrl", wb_ctrl, 0);
    chk("rstw wb_exout", wb_exout, 0);
    chk("rstw wb_rw", wb_rw, 0);
    chk("rstw wb_prrd", wb_prrd, 0);
    chk("rstw wb_addr_in_dm", wb_addr_in_dm, 0);
    chk("rstw bus_err", bus_err, 0);
    @(negedge clk);
    chk("rstw pr_req", pr_req, 0);
    chk("rstw mem_stall", mem_stall, 0);
    next_cycle();
    chk("rstw late bus_err", bus_err, 0);
    drive(1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 5'd0, 5'b00000, 1'b0, 1'b1);
    @(negedge clk);
    chk("rstw sw dm_we", dm_we, 1);
    chk("rstw sw stall", mem_stall, 0);
    next_cycle();
    chk("rstw sw wb_valid", wb_valid, 1);
    chk("rstw sw wb_exout", wb_exout, 32'h20);
    chk("rstw sw wb_addr_in_dm", wb_addr_in_dm, 1);
    $display("reset in WAIT, then sw 0x20");

    // Randomized instructions against the reference model
    do_reset();
    m_valid = 0; m_ctrl = 0; m_exout = 0; m_rw = 0; m_dm = 0; m_prrd = 0;
    for (int t = 0; t < 250; t++) begin
      logic        v, rd, wr, memop, al, indm, bgo, tmo;
      logic [31:0] a, d, rdat_done;
      logic [4:0]  c, r;
      int          k, done_j, ssel, op, nc;
      v    = ($urandom % 8) != 0;
      case ($urandom % 4)
        0:       a = $urandom_range(0, 32'h2FFF);
        1:       a = 32'h3000 + $urandom_range(0, 32'hFFF);
        2:       a = $urandom;
        default: a = ($urandom % 2) ? 32'h2FF8 + $urandom_range(0, 15) : $urandom_range(0, 15);
      endcase
      ssel = $urandom % 3;
      c    = {1'($urandom), 1'($urandom), ssel == 0, ssel == 1, 1'($urandom)};
      if (($urandom % 4) != 0) a = a - (a % size_of(c));
      op   = $urandom % 3;
      rd   = (op == 0);
      wr   = (op == 1);
      d    = $urandom;
      r    = 5'($urandom);
      k    = (($urandom % 8) == 0) ? 40 : $urandom_range(0, 4);
      memop  = v & (rd | wr);
      al     = ref_aligned(a, c);
      indm   = a < DM_END;
      bgo    = memop & al & ~indm;
      done_j = bgo ? ((k < TO) ? k : TO) : 0;
      tmo    = bgo && (k > TO);
      rdat_done = 32'h0;
      drive(v, a, d, r, c, rd, wr);
      for (int j = 0; j <= done_j; j++) begin
        pr_ready = bgo ? (j == k) : 1'($urandom);
        pr_rdata = $urandom;
        if (j == done_j) rdat_done = pr_rdata;
        @(negedge clk);
        chk("rnd mem_stall", mem_stall, j < done_j);
        chk("rnd pr_req", pr_req, bgo);
        chk("rnd dm_we", dm_we, v & wr & indm & al);
        if (bgo) begin
          chk("rnd pr_addr", pr_addr, a);
          chk("rnd pr_we", pr_we, wr);
          chk("rnd pr_be", pr_be, ref_be(a, c));
          if (wr) chk("rnd pr_wdata", pr_wdata, ref_wdata(d, c));
        end
        if (v & wr & indm & al) begin
          chk("rnd dm_be", dm_be, ref_be(a, c));
          chk("rnd dm_wdata", dm_wdata, ref_wdata(d, c));
        end
        next_cycle();
        if (j < done_j) begin
          chk("rnd bubble wb_valid", wb_valid, 0);
          chk("rnd bubble wb_ctrl", wb_ctrl, 0);
        end
      end
      m_aerr = memop & ~al;
      m_berr = tmo;
      if (v) begin
        m_valid = 1;
        m_ctrl  = {c[4] & ~m_aerr & ~tmo, c[3:0]};
        m_exout = a;
        m_rw    = r;
        m_dm    = indm;
        if (bgo) m_prrd = tmo ? 32'h0 : rdat_done;
      end else begin
        m_valid = 0;
        m_ctrl  = 0;
      end
      chk("rnd wb_valid", wb_valid, m_valid);
      chk("rnd wb_ctrl", wb_ctrl, m_ctrl);
      chk("rnd wb_exout", wb_exout, m_exout);
      chk("rnd wb_rw", wb_rw, m_rw);
      chk("rnd wb_addr_in_dm", wb_addr_in_dm, m_dm);
      chk("rnd wb_prrd", wb_prrd, m_prrd);
      chk("rnd addr_err", addr_err, m_aerr);
      chk("rnd bus_err", bus_err, m_berr);
      nc = done_j + 1;
      $display("txn %0d v=%0d addr=%08h rd=%0d wr=%0d ctrl=%05b cycles=%0d", t, v, a, rd, wr, c, nc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
